// File: rtl/dtree_frame_ctrl.sv
// dtree_frame_ctrl: sequencing controller for the combinational decision-tree
// classifier. It collects one frame of NUM_FEAT feature bytes from a serial
// stream, holds them on tree_feat, waits EVAL_CYCLES for the tree to settle,
// latches tree_class and returns it over a valid/ready handshake.
// Malformed frames (short or long) return out_err=1 with out_class=0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         byte stream handshake
//   in_data, in_last          feature byte, end-of-frame marker
//   tree_feat                 feature registers, slot k at [k*FEAT_W +: FEAT_W]
//   tree_class                classifier result (sampled at the end of EVAL)
//   out_valid/out_ready       result handshake
//   out_class, out_err        latched class, malformed-frame flag
//   busy                      low only when idle between frames
//   sample_count              saturating count of error-free results delivered
module dtree_frame_ctrl #(
    parameter int unsigned NUM_FEAT    = 5,
    parameter int unsigned FEAT_W      = 8,
    parameter int unsigned CLASS_W     = 5,
    parameter int unsigned EVAL_CYCLES = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FEAT_W-1:0]            in_data,
    input  logic                         in_last,
    output logic [NUM_FEAT*FEAT_W-1:0]   tree_feat,
    input  logic [CLASS_W-1:0]           tree_class,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CLASS_W-1:0]           out_class,
    output logic                         out_err,
    output logic                         busy,
    output logic [CNT_W-1:0]             sample_count
);

    localparam int unsigned IDX_W  = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam int unsigned EC_W   = $clog2(EVAL_CYCLES + 1);
    localparam int unsigned FEAT_TW = NUM_FEAT * FEAT_W;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_DRAIN  = 2'd1,
        S_EVAL   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [EC_W-1:0]      cnt, cnt_n;
    logic [FEAT_TW-1:0]   feat_n;
    logic [CLASS_W-1:0]   class_n;
    logic                 err_n;
    logic                 valid_n;
    logic [CNT_W-1:0]     count_n;
    logic                 in_ready_n;
    logic                 busy_n;
    logic                 in_xfer;

    assign in_xfer = in_valid && in_ready;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LOAD;
            idx          <= '0;
            cnt          <= '0;
            tree_feat    <= '0;
            out_class    <= '0;
            out_err      <= 1'b0;
            out_valid    <= 1'b0;
            sample_count <= '0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            cnt          <= cnt_n;
            tree_feat    <= feat_n;
            out_class    <= class_n;
            out_err      <= err_n;
            out_valid    <= valid_n;
            sample_count <= count_n;
            in_ready     <= in_ready_n;
            busy         <= busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        feat_n  = tree_feat;
        class_n = out_class;
        err_n   = out_err;
        valid_n = out_valid;
        count_n = sample_count;

        unique case (state)
            S_LOAD: begin
                if (in_xfer) begin
                    feat_n[idx*FEAT_W +: FEAT_W] = in_data;
                    if (idx == IDX_W'(NUM_FEAT - 1)) begin
                        idx_n = '0;
                        if (in_last) begin
                            state_n = S_EVAL;
                            cnt_n   = EC_W'(EVAL_CYCLES);
                        end else begin
                            state_n = S_DRAIN;
                        end
                    end else if (in_last) begin
                        // Short frame: report an error immediately
                        idx_n   = '0;
                        state_n = S_RESULT;
                        err_n   = 1'b1;
                        class_n = '0;
                        valid_n = 1'b1;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (in_xfer && in_last) begin
                    state_n = S_RESULT;
                    err_n   = 1'b1;
                    class_n = '0;
                    valid_n = 1'b1;
                end
            end
            S_EVAL: begin
                cnt_n = cnt - EC_W'(1);
                if (cnt <= EC_W'(1)) begin
                    cnt_n   = '0;
                    class_n = tree_class;
                    err_n   = 1'b0;
                    state_n = S_RESULT;
                end
            end
            S_RESULT: begin
                // out_valid rises one cycle after entry from EVAL
                if (out_valid && out_ready) begin
                    valid_n = 1'b0;
                    state_n = S_LOAD;
                    if (!out_err && (sample_count != {CNT_W{1'b1}})) begin
                        count_n = sample_count + CNT_W'(1);
                    end
                end else begin
                    valid_n = 1'b1;
                end
            end
            default: state_n = S_LOAD;
        endcase

        in_ready_n = (state_n == S_LOAD) || (state_n == S_DRAIN);
        busy_n     = !((state_n == S_LOAD) && (idx_n == '0));
    end

endmodule

// File: tb/tb_dtree_frame_ctrl.sv
// Self-checking bench for dtree_frame_ctrl with a tree stub
// (tree_class = low bits of slot 4) and a frame-level reference model.
module tb_dtree_frame_ctrl;

    localparam int unsigned NF  = 5;
    localparam int unsigned FW  = 8;
    localparam int unsigned CW  = 5;
    localparam int unsigned EC  = 3;
    localparam int unsigned CNW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [FW-1:0]     in_data;
    logic              in_last;
    logic [NF*FW-1:0]  tree_feat;
    logic [CW-1:0]     tree_class;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_class;
    logic              out_err;
    logic              busy;
    logic [CNW-1:0]    sample_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] mfeat [NF];
    int         mcount;

    dtree_frame_ctrl #(
        .NUM_FEAT(NF), .FEAT_W(FW), .CLASS_W(CW), .EVAL_CYCLES(EC), .CNT_W(CNW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .tree_feat(tree_feat), .tree_class(tree_class),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err),
        .busy(busy), .sample_count(sample_count)
    );

    assign tree_class = tree_feat[4*FW +: CW];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_feat();
        logic [63:0] v = '0;
        for (int k = 0; k < int'(NF); k++) v[k*8 +: 8] = mfeat[k];
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic last);
        int   guard = 0;
        logic acc = 1'b0;
        if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!acc && guard < 50) begin
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("byte_accept", 64'(acc), 64'd1);
    endtask

    task automatic send_frame(input int len, input logic [7:0] b [8], input int stall);
        logic          good;
        logic [CW-1:0] exp_class;
        int            lat;
        for (int i = 0; i < len; i++) begin
            if (i < int'(NF)) mfeat[i] = b[i];
        end
        good      = (len == int'(NF));
        exp_class = good ? mfeat[4][CW-1:0] : '0;
        out_ready = (stall == 0);
        for (int i = 0; i < len; i++) send_byte(b[i], (i == len - 1));
        check("busy_after_last", 64'(busy), 64'd1);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), good ? 64'(EC + 1) : 64'd0);
        check("out_class", 64'(out_class), 64'(exp_class));
        check("out_err", 64'(out_err), 64'(!good));
        check("in_ready_result", 64'(in_ready), 64'd0);
        check("tree_feat", 64'(tree_feat), model_feat());
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_class", 64'(out_class), 64'(exp_class));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        if (good && mcount < (1 << CNW) - 1) mcount++;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("sample_count", 64'(sample_count), 64'(mcount));
        check("in_ready_idle", 64'(in_ready), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);
        check("feat_kept", 64'(tree_feat), model_feat());
        out_ready = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_class", 64'(out_class), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_count", 64'(sample_count), 64'd0);
        check("rst_feat", 64'(tree_feat), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [7:0] fr [8];
        int         len;
        int         r;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < int'(NF); k++) mfeat[k] = '0;
        mcount = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset();

        // Nominal frame
        fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h3A, 8'h00, 8'h00, 8'h00};
        send_frame(5, fr, 0);
        // Backpressure for 10 cycles
        send_frame(5, fr, 10);
        // Short frame then a good frame
        fr = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(3, fr, 2);
        fr = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h17, 8'h00, 8'h00, 8'h00};
        send_frame(5, fr, 1);
        // Long frame, bytes 6-7 discarded
        fr = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h6B, 8'hEE, 8'hFF, 8'h00};
        send_frame(7, fr, 1);

        // Reset mid-frame
        send_byte(8'h99, 1'b0);
        send_byte(8'h88, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < int'(NF); k++) mfeat[k] = '0;
        mcount = 0;
        check_reset();
        fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00};
        send_frame(5, fr, 0);

        // Back-to-back good frames, driving the counter into saturation
        for (int n = 0; n < 18; n++) begin
            for (int i = 0; i < 8; i++) fr[i] = 8'($urandom);
            send_frame(5, fr, 0);
        end
        // Random mix of frame lengths and backpressure
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 8; i++) fr[i] = 8'($urandom);
            r = int'($urandom_range(9));
            if (r < 6)      len = 5;
            else if (r < 8) len = int'($urandom_range(1, 4));
            else            len = int'($urandom_range(6, 8));
            send_frame(len, fr, int'($urandom_range(3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
